// File: rtl/line_fill_arbiter.sv
// Round-robin arbiter sharing one AXI4 read channel (AR/R) between NUM_REQ
// cache line-fill requesters. Each grant issues one INCR burst of BEATS beats
// and forwards the returned beats to the owner, flagging errors on the last beat.
module line_fill_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_SIZE  = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BEATS      = 4
) (
    input  logic                           i_aclk,
    input  logic                           i_areset,
    input  logic [NUM_REQ-1:0]             i_req,
    input  logic [NUM_REQ*ADDR_SIZE-1:0]   i_addr,
    output logic [NUM_REQ-1:0]             o_grant,
    output logic [NUM_REQ-1:0]             o_rvalid,
    output logic [DATA_WIDTH-1:0]          o_rdata,
    output logic                           o_rlast,
    output logic [NUM_REQ-1:0]             o_err,
    output logic [ADDR_SIZE-1:0]           o_araddr,
    output logic [7:0]                     o_arlen,
    output logic [2:0]                     o_arsize,
    output logic [1:0]                     o_arburst,
    output logic                           o_arvalid,
    input  logic                           i_arready,
    input  logic [DATA_WIDTH-1:0]          i_rdata,
    input  logic [1:0]                     i_rresp,
    input  logic                           i_rlast,
    input  logic                           i_rvalid,
    output logic                           o_rready
);

    localparam int unsigned PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned OFF_W    = $clog2(BEATS * DATA_WIDTH / 8);
    localparam int unsigned SIZE_LOG = $clog2(DATA_WIDTH / 8);
    localparam logic [8:0]  BEATS_C  = 9'(BEATS);
    // Clears the byte offset within one cache line.
    localparam logic [ADDR_SIZE-1:0] ALIGN_MASK = {ADDR_SIZE{1'b1}} << OFF_W;

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_t;

    state_t               state;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     owner;
    logic [8:0]           beat_cnt;
    logic                 err_flag;
    logic [ADDR_SIZE-1:0] araddr_r;
    logic                 arvalid_r;
    logic                 rready_r;

    logic [PTR_W-1:0]     winner;
    logic                 found;
    logic [PTR_W-1:0]     rr_next;
    logic [ADDR_SIZE-1:0] win_addr;
    logic [NUM_REQ-1:0]   winner_oh;
    logic [NUM_REQ-1:0]   owner_oh;
    logic [8:0]           beat_num;
    logic                 resp_bad;
    logic                 final_err;
    logic                 beat_fire;

    assign o_arlen   = 8'(BEATS - 1);
    assign o_arsize  = 3'(SIZE_LOG);
    assign o_arburst = 2'b01;
    assign o_araddr  = araddr_r;
    assign o_arvalid = arvalid_r;
    assign o_rready  = rready_r;

    // Pick the first requesting index at or after the round-robin pointer.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            int unsigned idx;
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!found && i_req[idx]) begin
                winner = PTR_W'(idx);
                found  = 1'b1;
            end
        end
        rr_next  = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + PTR_W'(1);
        win_addr = i_addr[int'(winner)*ADDR_SIZE +: ADDR_SIZE] & ALIGN_MASK;
    end

    // One-hot decodes of the arbitration winner and the current fill owner.
    always_comb begin
        winner_oh = '0;
        owner_oh  = '0;
        winner_oh[winner] = 1'b1;
        owner_oh[owner]   = 1'b1;
    end

    // Beat accounting; an error is reported if any response was bad or the count was off.
    always_comb begin
        beat_num  = beat_cnt + 9'd1;
        resp_bad  = (i_rresp != 2'b00);
        final_err = err_flag | resp_bad | (beat_num != BEATS_C);
        beat_fire = (state == StData) && i_rvalid && !i_areset;
    end

    // Requester-facing outputs; forced low while reset is asserted.
    always_comb begin
        o_grant  = '0;
        o_rvalid = '0;
        o_rdata  = '0;
        o_rlast  = 1'b0;
        o_err    = '0;
        if ((state == StIdle) && found && !i_areset) begin
            o_grant = winner_oh;
        end
        if (beat_fire) begin
            o_rvalid = owner_oh;
            o_rdata  = i_rdata;
            o_rlast  = i_rlast;
            if (i_rlast && final_err) begin
                o_err = owner_oh;
            end
        end
    end

    // Fill FSM with registered AXI control outputs.
    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            state     <= StIdle;
            rr_ptr    <= '0;
            owner     <= '0;
            beat_cnt  <= '0;
            err_flag  <= 1'b0;
            araddr_r  <= '0;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (found) begin
                        owner     <= winner;
                        araddr_r  <= win_addr;
                        rr_ptr    <= rr_next;
                        arvalid_r <= 1'b1;
                        beat_cnt  <= '0;
                        err_flag  <= 1'b0;
                        state     <= StAddr;
                    end
                end
                StAddr: begin
                    if (i_arready) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        state     <= StData;
                    end
                end
                StData: begin
                    if (i_rvalid) begin
                        if (i_rlast) begin
                            rready_r <= 1'b0;
                            beat_cnt <= '0;
                            err_flag <= 1'b0;
                            state    <= StIdle;
                        end else begin
                            // Saturate so an overlong burst cannot wrap back to a valid count.
                            if (beat_cnt != BEATS_C) begin
                                beat_cnt <= beat_num;
                            end
                            err_flag <= err_flag | resp_bad | (beat_num >= BEATS_C);
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_fill_arbiter.sv
// Directed testbench for line_fill_arbiter (NUM_REQ=2, 32-bit data, 4-beat lines).
module tb_line_fill_arbiter;

    logic        clk;
    logic        areset;
    logic [1:0]  req;
    logic [63:0] addr;
    logic [1:0]  grant;
    logic [1:0]  rvalid;
    logic [31:0] rdata;
    logic        rlast;
    logic [1:0]  err;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic        s_rvalid;
    logic        rready;

    int checks   = 0;
    int failures = 0;

    line_fill_arbiter #(
        .NUM_REQ    (2),
        .ADDR_SIZE  (32),
        .DATA_WIDTH (32),
        .BEATS      (4)
    ) dut (
        .i_aclk    (clk),
        .i_areset  (areset),
        .i_req     (req),
        .i_addr    (addr),
        .o_grant   (grant),
        .o_rvalid  (rvalid),
        .o_rdata   (rdata),
        .o_rlast   (rlast),
        .o_err     (err),
        .o_araddr  (araddr),
        .o_arlen   (arlen),
        .o_arsize  (arsize),
        .o_arburst (arburst),
        .o_arvalid (arvalid),
        .i_arready (arready),
        .i_rdata   (s_rdata),
        .i_rresp   (s_rresp),
        .i_rlast   (s_rlast),
        .i_rvalid  (s_rvalid),
        .o_rready  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // One R beat from the slave; checks forwarding, then advances past the edge.
    task automatic beat(input logic [31:0] d, input logic [1:0] resp, input logic last,
                        input logic [1:0] own, input logic exp_err);
        s_rvalid = 1'b1;
        s_rdata  = d;
        s_rresp  = resp;
        s_rlast  = last;
        #1;
        check("rvalid", rvalid, own);
        check("rdata", rdata, d);
        check("rlast", rlast, last);
        check("err", err, exp_err ? own : 2'b00);
        tick();
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        s_rresp  = 2'b00;
    endtask

    // A complete clean fill starting in IDLE with req/addr already driven.
    task automatic run_fill(input logic [1:0] exp_oh, input logic [31:0] exp_addr,
                            input logic [31:0] base, input logic drop);
        #1;
        check("grant", grant, exp_oh);
        tick();
        if (drop) req = 2'b00;
        #1;
        check("arvalid_addr", arvalid, 1'b1);
        check("araddr", araddr, exp_addr);
        check("grant_in_addr", grant, 2'b00);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check("arvalid_data", arvalid, 1'b0);
        check("rready_data", rready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            beat(base + 32'(i), 2'b00, (i == 3), exp_oh, 1'b0);
        end
    endtask

    initial begin
        areset   = 1'b1;
        req      = 2'b00;
        addr     = '0;
        arready  = 1'b0;
        s_rdata  = '0;
        s_rresp  = 2'b00;
        s_rlast  = 1'b0;
        s_rvalid = 1'b0;
        tick();
        tick();

        // Reset state; a request during reset is not granted.
        req = 2'b01;
        #1;
        check("rst_grant", grant, 2'b00);
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_rready", rready, 1'b0);
        check("rst_rvalid", rvalid, 2'b00);
        check("rst_araddr", araddr, 32'h0);
        check("rst_arlen", arlen, 8'd3);
        check("rst_arsize", arsize, 3'd2);
        check("rst_arburst", arburst, 2'b01);
        tick();

        // 1: single fill from requester 0.
        areset = 1'b0;
        addr[31:0] = 32'h0000_1234;
        run_fill(2'b01, 32'h0000_1230, 32'hA0, 1'b1);
        check("t1_idle_rready", rready, 1'b0);

        // 2: both requesters held from reset; grants alternate.
        areset = 1'b1;
        tick();
        areset = 1'b0;
        req = 2'b11;
        addr[31:0]  = 32'h0000_0100;
        addr[63:32] = 32'h0000_2004;
        for (int k = 0; k < 3; k++) begin
            run_fill(2'b01, 32'h0000_0100, 32'h100 + 32'(k * 16), 1'b0);
            run_fill(2'b10, 32'h0000_2000, 32'h200 + 32'(k * 16), 1'b0);
        end
        req = 2'b00;

        // 3: arready low for 5 cycles; AR stays stable, no beats accepted.
        req = 2'b01;
        addr[31:0] = 32'h0000_5678;
        #1;
        check("t3_grant", grant, 2'b01);
        tick();
        req = 2'b00;
        for (int k = 0; k < 5; k++) begin
            s_rvalid = 1'b1;
            #1;
            check("t3_arvalid", arvalid, 1'b1);
            check("t3_araddr", araddr, 32'h0000_5670);
            check("t3_rready", rready, 1'b0);
            check("t3_rvalid", rvalid, 2'b00);
            tick();
        end
        s_rvalid = 1'b0;
        arready  = 1'b1;
        #1;
        check("t3_arvalid6", arvalid, 1'b1);
        check("t3_araddr6", araddr, 32'h0000_5670);
        tick();
        arready = 1'b0;
        check("t3_rready_data", rready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            beat(32'hB0 + 32'(i), 2'b00, (i == 3), 2'b01, 1'b0);
        end

        // 4: SLVERR on beat 2 of requester 1; err only with the last beat.
        req = 2'b10;
        addr[63:32] = 32'h0000_3008;
        #1;
        check("t4_grant", grant, 2'b10);
        tick();
        req = 2'b00;
        check("t4_araddr", araddr, 32'h0000_3000);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        beat(32'hC0, 2'b00, 1'b0, 2'b10, 1'b0);
        beat(32'hC1, 2'b10, 1'b0, 2'b10, 1'b0);
        beat(32'hC2, 2'b00, 1'b0, 2'b10, 1'b0);
        beat(32'hC3, 2'b00, 1'b1, 2'b10, 1'b1);

        // 5: early rlast on beat 3; fill ends with err, FSM back in IDLE.
        req = 2'b01;
        addr[31:0] = 32'h0000_0044;
        #1;
        check("t5_grant", grant, 2'b01);
        tick();
        req = 2'b00;
        check("t5_araddr", araddr, 32'h0000_0040);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        beat(32'hD0, 2'b00, 1'b0, 2'b01, 1'b0);
        beat(32'hD1, 2'b00, 1'b0, 2'b01, 1'b0);
        beat(32'hD2, 2'b00, 1'b1, 2'b01, 1'b1);
        check("t5_rready", rready, 1'b0);
        check("t5_idle_grant0", grant, 2'b00);

        // 6: reset during beat 2; fill abandoned and pointer back to 0.
        req = 2'b01;
        addr[31:0] = 32'h0000_0080;
        #1;
        check("t6_grant_idle", grant, 2'b01);
        tick();
        req = 2'b00;
        check("t6_arvalid", arvalid, 1'b1);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        beat(32'hE0, 2'b00, 1'b0, 2'b01, 1'b0);
        s_rvalid = 1'b1;
        s_rdata  = 32'hE1;
        areset   = 1'b1;
        tick();
        req = 2'b11;
        #1;
        check("t6_rready", rready, 1'b0);
        check("t6_rvalid", rvalid, 2'b00);
        check("t6_grant_rst", grant, 2'b00);
        check("t6_arvalid_rst", arvalid, 1'b0);
        areset   = 1'b0;
        s_rvalid = 1'b0;
        #1;
        check("t6_grant_rr0", grant, 2'b01);
        tick();
        req = 2'b00;
        check("t6_araddr", araddr, 32'h0000_0080);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            beat(32'hF0 + 32'(i), 2'b00, (i == 3), 2'b01, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
